// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - N-channel L1 miss/write-through arbiter onto one memory request port
// One transaction in flight at a time; round-robin or fixed priority among channels.
module l1_mem_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH-1:0]          ch_burst,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_strobe,
  output logic [NUM_CH-1:0]          ch_wait,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       M_req,
  output logic                       M_write,
  output logic                       M_burst,
  output logic [ADDR_W-1:0]          M_addr,
  output logic [DATA_W-1:0]          M_in,
  output logic [DATA_W/8-1:0]        M_strobe,
  input  logic [DATA_W-1:0]          M_out,
  input  logic                       M_wait,
  input  logic                       M_valid,
  output logic                       err_spurious
);
  localparam int SW = DATA_W / 8;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t        state, state_next;
  logic [GW-1:0] grant, rr_ptr, win;
  logic          win_found;
  logic [CW-1:0] beat_cnt, beats_needed;
  logic          rd_burst;
  logic          accept, last_beat, complete;

  // Search starts at rr_ptr for round-robin, at channel 0 for fixed priority.
  always_comb begin : arbitrate
    int start;
    int idx;
    win       = '0;
    win_found = 1'b0;
    start     = (PRIO_MODE == 1) ? 0 : int'(rr_ptr);
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (start + k) % NUM_CH;
      if (!win_found && ch_req[idx]) begin
        win_found = 1'b1;
        win       = GW'(idx);
      end
    end
  end

  always_comb begin
    state_next   = state;
    M_req        = 1'b0;
    M_write      = 1'b0;
    M_burst      = 1'b0;
    M_addr       = '0;
    M_in         = '0;
    M_strobe     = '0;
    ch_valid     = '0;
    accept       = 1'b0;
    last_beat    = 1'b0;
    complete     = 1'b0;
    beats_needed = rd_burst ? CW'(BURST_LEN) : CW'(1);
    case (state)
      IDLE: begin
        if (win_found) state_next = ISSUE;
      end
      ISSUE: begin
        M_req    = 1'b1;
        M_write  = ch_write[grant];
        M_burst  = ch_burst[grant] & ~ch_write[grant];
        M_addr   = ch_addr[int'(grant)*ADDR_W +: ADDR_W];
        M_in     = ch_wdata[int'(grant)*DATA_W +: DATA_W];
        M_strobe = ch_strobe[int'(grant)*SW +: SW];
        accept   = ~M_wait;
        if (accept) begin
          if (ch_write[grant]) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RDATA;
          end
        end
      end
      RDATA: begin
        if (M_valid) begin
          ch_valid[grant] = 1'b1;
          last_beat       = (beat_cnt + CW'(1)) == beats_needed;
          if (last_beat) begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // An abort by reset never signals completion or delivers a beat.
    if (rst) begin
      complete = 1'b0;
      ch_valid = '0;
    end
  end

  assign ch_wait  = ch_req & ~(complete ? (NUM_CH'(1) << grant) : '0);
  assign ch_rdata = M_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      rd_burst     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (state == IDLE && win_found) grant <= win;
      if (state == ISSUE && accept && !ch_write[grant]) begin
        beat_cnt <= '0;
        rd_burst <= M_burst;
      end
      if (state == RDATA && M_valid) beat_cnt <= beat_cnt + CW'(1);
      if (complete && PRIO_MODE == 0)
        rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + GW'(1);
      if (M_valid && state != RDATA) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - directed and randomized bench for l1_mem_arbiter
// A transaction-level reference model checks every cycle of the random phase.
module tb_l1_mem_arbiter;
  localparam int NUM_CH = 3, ADDR_W = 32, DATA_W = 32, BURST_LEN = 4, SW = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_CH-1:0]        ch_req, ch_write, ch_burst;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*SW-1:0]     ch_strobe;
  logic [DATA_W-1:0]        M_out;
  logic                     M_wait, M_valid;

  logic [NUM_CH-1:0] ch_wait, ch_valid, fx_ch_wait, fx_ch_valid;
  logic [DATA_W-1:0] ch_rdata, M_in, fx_ch_rdata, fx_M_in;
  logic              M_req, M_write, M_burst, err_spurious;
  logic              fx_M_req, fx_M_write, fx_M_burst, fx_err_spurious;
  logic [ADDR_W-1:0] M_addr, fx_M_addr;
  logic [SW-1:0]     M_strobe, fx_M_strobe;

  l1_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .BURST_LEN(BURST_LEN), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_write(ch_write), .ch_burst(ch_burst),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_strobe(ch_strobe),
    .ch_wait(ch_wait), .ch_valid(ch_valid), .ch_rdata(ch_rdata),
    .M_req(M_req), .M_write(M_write), .M_burst(M_burst), .M_addr(M_addr),
    .M_in(M_in), .M_strobe(M_strobe), .M_out(M_out), .M_wait(M_wait),
    .M_valid(M_valid), .err_spurious(err_spurious));

  l1_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .BURST_LEN(BURST_LEN), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_write(ch_write), .ch_burst(ch_burst),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_strobe(ch_strobe),
    .ch_wait(fx_ch_wait), .ch_valid(fx_ch_valid), .ch_rdata(fx_ch_rdata),
    .M_req(fx_M_req), .M_write(fx_M_write), .M_burst(fx_M_burst), .M_addr(fx_M_addr),
    .M_in(fx_M_in), .M_strobe(fx_M_strobe), .M_out(M_out), .M_wait(M_wait),
    .M_valid(M_valid), .err_spurious(fx_err_spurious));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic req, input logic wr, input logic bu,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [SW-1:0] s);
    ch_req[i]   = req;
    ch_write[i] = wr;
    ch_burst[i] = bu;
    ch_addr[i*ADDR_W +: ADDR_W] = a;
    ch_wdata[i*DATA_W +: DATA_W] = d;
    ch_strobe[i*SW +: SW] = s;
  endtask

  task automatic do_reset;
    tick;
    rst = 1'b1; ch_req = '0; ch_write = '0; ch_burst = '0;
    ch_addr = '0; ch_wdata = '0; ch_strobe = '0;
    M_wait = 1'b0; M_valid = 1'b0; M_out = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Reference winner: first requester at or after start, wrapping.
  function automatic int pick(input logic [NUM_CH-1:0] req, input int start);
    for (int k = 0; k < NUM_CH; k++)
      if (req[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
    return -1;
  endfunction

  int phase, cur, beats_left, rr_next, owed, comp;
  logic [NUM_CH-1:0] done, exp_w;

  initial begin
    rst = 1'b1; ch_req = 3'b101; ch_write = '0; ch_burst = '0;
    ch_addr = '0; ch_wdata = '0; ch_strobe = '0;
    M_wait = 1'b0; M_valid = 1'b0; M_out = '0;
    tick;
    smp;
    check("rst_mreq", M_req, 0);
    check("rst_maddr", {M_write, M_burst, M_addr, M_in, M_strobe}, 0);
    check("rst_valid", ch_valid, 0);
    check("rst_err", err_spurious, 0);
    check("rst_wait_follows_req", ch_wait, 3'b101);
    tick;
    ch_req = '0; rst = 1'b0;

    // single write on ch1
    tick;
    set_ch(1, 1, 1, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    smp;
    check("wr_c0_mreq", M_req, 0);
    check("wr_c0_wait", ch_wait, 3'b010);
    tick;
    smp;
    check("wr_c1_mreq", M_req, 1);
    check("wr_c1_fields", {M_write, M_burst, M_addr, M_in, M_strobe},
          {1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF});
    check("wr_c1_wait", ch_wait, 3'b000);
    tick;
    ch_req[1] = 1'b0;
    smp;
    check("wr_c2_mreq", M_req, 0);

    // burst read on ch0 with a gap between beats
    tick;
    set_ch(0, 1, 0, 1, 32'h0000_2000, 32'h0, 4'h0);
    smp;
    tick;
    smp;
    check("br_issue", {M_req, M_write, M_burst, M_addr}, {1'b1, 1'b0, 1'b1, 32'h0000_2000});
    for (int c = 0; c < 7; c++) begin
      tick;
      M_valid = (c % 2 == 0);
      M_out   = 32'h11 * (c / 2 + 1);
      smp;
      check("br_valid", ch_valid, (c % 2 == 0) ? 3'b001 : 3'b000);
      if (c % 2 == 0) check("br_rdata", ch_rdata, 32'h11 * (c / 2 + 1));
      check("br_wait", ch_wait, (c == 6) ? 3'b000 : 3'b001);
      check("br_mreq", M_req, 0);
    end
    tick;
    M_valid = 1'b0; ch_req[0] = 1'b0;
    smp;
    check("br_after", {M_req, ch_wait}, 0);

    // all channels requesting single reads: rotating vs fixed grants
    do_reset;
    tick;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1, 0, 0, 32'h100 * (i + 1), 32'h0, 4'h0);
    smp;
    for (int k = 0; k < 6; k++) begin
      tick;
      smp;
      check("rr_mreq", M_req, 1);
      check("rr_grant_addr", M_addr, 32'h100 * (k % 3 + 1));
      check("fx_grant_addr", fx_M_addr, 32'h100);
      tick;
      M_valid = 1'b1; M_out = 32'(k);
      smp;
      check("rr_valid", ch_valid, NUM_CH'(1) << (k % 3));
      tick;
      M_valid = 1'b0;
      if (k == 5) ch_req = '0;
      smp;
      check("rr_idle_mreq", M_req, 0);
    end

    // write stalled by M_wait for five cycles
    tick;
    set_ch(2, 1, 1, 0, 32'h0000_3000, 32'hCAFE_F00D, 4'h5);
    M_wait = 1'b1;
    smp;
    for (int c = 0; c < 6; c++) begin
      tick;
      M_wait = (c < 5);
      smp;
      check("stall_fields", {M_req, M_write, M_addr, M_in, M_strobe},
            {1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h5});
      check("stall_wait", ch_wait, (c == 5) ? 3'b000 : 3'b100);
    end
    tick;
    ch_req[2] = 1'b0; M_wait = 1'b0;
    smp;
    check("stall_after", M_req, 0);

    // spurious beat while idle
    tick;
    M_valid = 1'b1; M_out = 32'h55;
    smp;
    check("spur_valid", ch_valid, 0);
    tick;
    M_valid = 1'b0;
    smp;
    check("spur_err", err_spurious, 1);

    // reset on the 2nd beat of a burst, after rr_ptr has moved to 1
    tick;
    set_ch(0, 1, 1, 0, 32'h0000_4000, 32'h1, 4'hF);
    smp;
    tick;
    smp;
    check("abort_wr_done", ch_wait, 0);
    tick;
    ch_req[0] = 1'b0;
    smp;
    tick;
    set_ch(1, 1, 0, 1, 32'h0000_5000, 32'h0, 4'h0);
    smp;
    tick;
    smp;
    check("abort_issue", M_addr, 32'h0000_5000);
    tick;
    M_valid = 1'b1; M_out = 32'hA1;
    smp;
    check("abort_beat1", {ch_valid, ch_wait}, {3'b010, 3'b010});
    check("abort_err_sticky", err_spurious, 1);
    tick;
    M_out = 32'hA2; rst = 1'b1;
    smp;
    check("abort_no_completion", ch_wait, 3'b010);
    tick;
    rst = 1'b0;
    M_out = 32'hA3;
    set_ch(0, 1, 0, 0, 32'h0000_6000, 32'h0, 4'h0);
    set_ch(1, 1, 0, 0, 32'h0000_7000, 32'h0, 4'h0);
    smp;
    check("post_rst_outputs", {M_req, M_write, M_burst, M_addr, ch_valid}, 0);
    check("post_rst_err", err_spurious, 0);
    tick;
    M_valid = 1'b0;
    smp;
    check("post_rst_grant", {M_req, M_addr}, {1'b1, 32'h0000_6000});
    check("inflight_err", err_spurious, 1);
    tick;
    M_valid = 1'b1; M_out = 32'h77;
    smp;
    check("post_rst_beat", {ch_valid, ch_rdata, ch_wait}, {3'b001, 32'h77, 3'b010});
    tick;
    M_valid = 1'b0; ch_req[0] = 1'b0;
    smp;
    tick;
    smp;
    check("post_rst_next", {M_req, M_addr}, {1'b1, 32'h0000_7000});
    tick;
    M_valid = 1'b1;
    smp;
    check("post_rst_beat2", {ch_valid, ch_wait}, {3'b010, 3'b000});
    tick;
    M_valid = 1'b0; ch_req = '0;
    smp;

    // randomized traffic against the transaction-level model
    do_reset;
    phase = 0; cur = 0; beats_left = 0; rr_next = 0; owed = 0; done = '0;
    for (int t = 0; t < 3000; t++) begin
      tick;
      for (int i = 0; i < NUM_CH; i++) begin
        if (done[i] || !ch_req[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_ch(i, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)));
          else
            ch_req[i] = 1'b0;
        end
      end
      done    = '0;
      M_wait  = ($urandom_range(0, 2) == 0);
      M_valid = (owed > 0) && ($urandom_range(0, 1) == 0);
      M_out   = 32'($urandom);
      smp;
      comp = -1;
      case (phase)
        0: begin
          check("rnd_idle_mreq", M_req, 0);
          check("rnd_idle_valid", ch_valid, 0);
          if (ch_req != 0) begin
            cur   = pick(ch_req, rr_next);
            phase = 1;
          end
        end
        1: begin
          check("rnd_issue_mreq", M_req, 1);
          check("rnd_issue_fields", {M_write, M_burst, M_addr, M_in, M_strobe},
                {ch_write[cur], ch_burst[cur] & ~ch_write[cur],
                 ch_addr[cur*ADDR_W +: ADDR_W], ch_wdata[cur*DATA_W +: DATA_W],
                 ch_strobe[cur*SW +: SW]});
          check("rnd_issue_valid", ch_valid, 0);
          if (!M_wait) begin
            if (ch_write[cur]) begin
              comp  = cur;
              phase = 0;
            end else begin
              beats_left = ch_burst[cur] ? BURST_LEN : 1;
              owed       = M_burst ? BURST_LEN : 1;
              phase      = 2;
            end
          end
        end
        default: begin
          check("rnd_rd_mreq", M_req, 0);
          if (M_valid) begin
            owed--;
            check("rnd_rd_valid", ch_valid, NUM_CH'(1) << cur);
            check("rnd_rd_data", ch_rdata, M_out);
            beats_left--;
            if (beats_left == 0) begin
              comp  = cur;
              phase = 0;
            end
          end else begin
            check("rnd_rd_novalid", ch_valid, 0);
          end
        end
      endcase
      exp_w = ch_req;
      if (comp >= 0) begin
        exp_w[comp] = 1'b0;
        done[comp]  = 1'b1;
        rr_next     = (comp + 1) % NUM_CH;
      end
      check("rnd_wait", ch_wait, exp_w);
    end
    check("rnd_no_spurious", err_spurious, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Parametrised N-channel arbiter that merges L1 cache miss/write-through traffic from NUM_CH requesters (instruction cache, data cache, future prefetch or DMA ports) onto a single memory-side request port. It uses the same req/wait/valid/burst handshake the L1 caches already drive. It adds round-robin or fixed priority, a configurable burst length and spurious-beat detection. It sits between the CPU-with-cache cluster and the AXI master wrapper.

## Interface
Parameters:
- NUM_CH, 2: number of requester channels (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- BURST_LEN, 4: beats returned for a burst read (1..16).
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed, channel 0 highest.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request; held with all fields stable until completion.
- ch_write  in  NUM_CH  1 = single-beat write, 0 = read.
- ch_burst  in  NUM_CH  read burst of BURST_LEN beats; ignored when ch_write=1.
- ch_addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed write data.
- ch_strobe  in  NUM_CH*DATA_W/8  packed byte strobes.
- ch_wait  out  NUM_CH  high while ch_req[i] is set and its transaction has not completed.
- ch_valid  out  NUM_CH  read beat for channel i is on ch_rdata this cycle.
- ch_rdata  out  DATA_W  shared read data (M_out pass-through).
- M_req  out  1  memory request.
- M_write  out  1  memory write.
- M_burst  out  1  memory burst read.
- M_addr  out  ADDR_W  memory address.
- M_in  out  DATA_W  memory write data.
- M_strobe  out  DATA_W/8  memory byte strobes.
- M_out  in  DATA_W  memory read data.
- M_wait  in  1  memory not accepting; a request is accepted when M_req=1 and M_wait=0.
- M_valid  in  1  read beat valid.
- err_spurious  out  1  sticky; set by an M_valid seen outside RDATA; cleared only by rst.

## Operation
- States: IDLE, ISSUE, RDATA.
- IDLE:
  - If any ch_req is set, select a winner and register it in grant (width clog2(NUM_CH), min 1), then go to ISSUE.
  - Round-robin: the first requesting index at or after rr_ptr, wrapping modulo NUM_CH.
  - Fixed: the lowest requesting index.
- ISSUE:
  - M_req=1. M_write, M_burst, M_addr, M_in and M_strobe are combinationally muxed from channel grant.
  - M_burst = ch_burst[grant] & ~ch_write[grant].
  - On accept with a write: the transaction completes this cycle; go to IDLE.
  - On accept with a read: clear beat_cnt and go to RDATA.
- RDATA:
  - M_req=0. Each M_valid raises ch_valid[grant] and increments beat_cnt (width clog2(BURST_LEN+1)).
  - Expected beats: BURST_LEN if burst, else 1.
  - The cycle carrying the final expected beat is the completion cycle; go to IDLE.
- Completion:
  - ch_wait[grant] drops to 0 for exactly the completion cycle.
  - ch_wait[i] = ch_req[i] & ~(completion & grant==i).
  - Round-robin mode sets rr_ptr = (grant+1) mod NUM_CH at completion. Fixed mode never updates rr_ptr.
- Requester rules:
  - Requesters deassert ch_req or present a new request the cycle after completion.
  - A ch_req dropped mid-transaction is a protocol violation. The arbiter ignores it and finishes the transaction.
- M_valid outside RDATA is ignored for data purposes: no ch_valid, no count change. It sets err_spurious.
- Outside ISSUE, all M_* request outputs are 0.

## Timing
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, err_spurious=0.
  - M_req, M_write, M_burst = 0; M_addr, M_in, M_strobe = 0.
  - ch_valid = 0.
  - ch_wait follows ch_req combinationally, even during reset.
- rst mid-transaction aborts to IDLE the next cycle with no completion signalled. Any memory beats still in flight set err_spurious.
- Latency: ch_req seen in IDLE at cycle 0 puts M_req=1 at cycle 1. Zero-wait write completion is at cycle 1, and the next arbitration is at cycle 2.
- Read with zero memory latency: accept at cycle 1, first beat possible at cycle 2. A burst completes no earlier than cycle 1+BURST_LEN.
- No two transactions overlap; at most one is outstanding.
- Simultaneous requests: exactly one winner per IDLE cycle; losers keep ch_wait=1.
- Round-robin guarantees each continuously requesting channel is granted within NUM_CH transactions.

## Test plan
- Single write, ch1, addr 0x0000_1000, data 0xDEADBEEF, strobe 0xF, M_wait=0 -> M_req=1 at cycle 1 with those values; ch_wait[1]=0 at cycle 1; M_req=0 at cycle 2.
- Burst read ch0, BURST_LEN=4, memory returns beats 0x11,0x22,0x33,0x44 with one idle cycle between -> four ch_valid[0] pulses with matching ch_rdata; ch_wait[0] drops on the 4th beat only; ch_valid[1] stays 0.
- Round-robin, NUM_CH=3, all channels requesting continuously with single reads -> grant order 0,1,2,0,1,2. With PRIO_MODE=1 -> grants 0 every time.
- M_wait held high 5 cycles during ISSUE -> M_req and all M_* fields held stable for 6 cycles; completion is only after accept.
- Spurious M_valid in IDLE -> no ch_valid, err_spurious=1 and stays 1 until rst.
- rst asserted on the 2nd beat of a burst read -> next cycle state IDLE, all outputs at reset values, rr_ptr=0; the next request is granted normally.
